// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline.
//   state_e    : access FSM encoding (IDLE, BUSY)
//   CNT_W      : width of the access latency counter (MEM_LAT up to 15)
//   word_addr  : byte address -> word address (drops the byte offset)
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  // Word address of a byte address; the caller keeps the low ADDR_W bits,
  // so out-of-range addresses wrap modulo the RAM depth.
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word-addressed data RAM, 32-bit words, 2**ADDR_W deep.
//   Clk   in   clock, write on posedge
//   we    in   write enable
//   addr  in   word index
//   wdata in   write data
//   rdata out  combinational read of addr
// Contents are not reset.
module data_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access with a
// configurable latency, branch resolution, and the MEM/WB register.
//   Clk, Rst_n            clock, synchronous active-low reset
//   mem_alu_result  in    byte address (lw/sw) or R-type result
//   mem_busB        in    store data
//   mem_Rw          in    destination register
//   mem_RegWr       in    register-write control
//   mem_MemWr       in    store
//   mem_MemtoReg    in    load
//   mem_Zero        in    ALU zero flag
//   mem_Branch      in    beq in MEM
//   mem_stall       out   freeze upstream while an access is in flight
//   mem_PCSrc       out   branch taken
//   wb_RegWr        out   registered register-file write enable
//   wb_Rw           out   registered destination register
//   wb_busW         out   registered write-back data
module mem_stage_wb
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_busB,
  input  logic [4:0]  mem_Rw,
  input  logic        mem_RegWr,
  input  logic        mem_MemWr,
  input  logic        mem_MemtoReg,
  input  logic        mem_Zero,
  input  logic        mem_Branch,
  output logic        mem_stall,
  output logic        mem_PCSrc,
  output logic        wb_RegWr,
  output logic [4:0]  wb_Rw,
  output logic [31:0] wb_busW
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_stall;
  logic             w_complete;

  logic [29:0]       w_word;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_rdata;
  logic              w_ram_we;

  // A store wins over a simultaneous load flag.
  logic w_memop;
  logic w_store;
  logic w_load;
  logic w_regwr_nxt;

  assign w_memop     = mem_MemWr | mem_MemtoReg;
  assign w_store     = mem_MemWr;
  assign w_load      = mem_MemtoReg & ~mem_MemWr;
  assign w_regwr_nxt = mem_RegWr & ~mem_MemWr;

  assign w_word     = word_addr(mem_alu_result);
  assign w_ram_addr = w_word[ADDR_W-1:0];

  // Branches are never memory ops, so PCSrc needs no FSM qualification.
  assign mem_PCSrc = mem_Branch & mem_Zero;
  assign mem_stall = w_stall;

  // The RAM write is held back until the completion edge so that address
  // and data are sampled only once; reset abandons a pending store.
  assign w_ram_we = w_complete & w_store & Rst_n;

  data_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .Clk  (Clk),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .wdata(mem_busB),
    .rdata(w_ram_rdata)
  );

  // w_complete marks the edge at which the instruction in MEM retires.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_memop || MEM_LAT == 1) begin
          w_complete = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt > CNT_W'(1)) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_complete  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      wb_RegWr <= 1'b0;
      wb_Rw    <= '0;
      wb_busW  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_complete) begin
        wb_RegWr <= w_regwr_nxt;
        wb_Rw    <= mem_Rw;
        wb_busW  <= w_load ? w_ram_rdata : mem_alu_result;
      end else begin
        // Stall cycles carry a bubble so each instruction writes back once.
        wb_RegWr <= 1'b0;
      end
    end
  end

endmodule
